// File: rtl/doorlock_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : doorlock_pkg
// Description : Shared definitions for the doorlock_param controller:
//               FSM state encoding, button-index width helper and a
//               one-hot-to-index decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package doorlock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_ENTER = 3'd1;
    localparam state_t c_ST_AUTH  = 3'd2;
    localparam state_t c_ST_PROG  = 3'd3;
    localparam state_t c_ST_OK    = 3'd4;
    localparam state_t c_ST_FAIL  = 3'd5;
    localparam state_t c_ST_LOCK  = 3'd6;

    // Width of a digit value; a single-button keypad still needs one bit.
    function automatic int bt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit. Multi-bit presses are flagged as wrong
    // separately, so the choice of bit only matters for what gets stored
    // while reprogramming.
    function automatic int unsigned oh_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = $unsigned(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/doorlock_param_if.sv
`default_nettype none
// ============================================================================
// Module      : doorlock_param_if
// Description : Keypad / LED bundle of the door-lock controller.
//               master : drives start, prog, bt; observes the LED outputs
//               slave  : the controller itself
//   start     - session request level (rising edge opens a session)
//   prog      - 1 = reprogram session, sampled with the start edge
//   bt        - raw button levels, synchronous to clk
//   led_digit - per-digit progress (thermometer)
//   led_ok    - success pulse
//   led_fail  - failure pulse
//   led_lock  - lockout active
//   busy      - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface doorlock_param_if #(
    parameter int N_BT     = 3,
    parameter int CODE_LEN = 3
);
    logic                start;
    logic                prog;
    logic [N_BT-1:0]     bt;
    logic [CODE_LEN-1:0] led_digit;
    logic                led_ok;
    logic                led_fail;
    logic                led_lock;
    logic                busy;

    modport master (
        output start, prog, bt,
        input  led_digit, led_ok, led_fail, led_lock, busy
    );

    modport slave (
        input  start, prog, bt,
        output led_digit, led_ok, led_fail, led_lock, busy
    );
endinterface
`default_nettype wire

// File: rtl/doorlock_param_edge.sv
`default_nettype none
// ============================================================================
// Module      : doorlock_edge
// Description : WIDTH-bit two-flop rising-edge detector. o_rise is high for
//               exactly one cycle, the cycle after i_sig was first seen high;
//               a held input produces one pulse only.
//   clk    - system clock
//   n_rst  - asynchronous active-low reset
//   i_sig  - input levels, synchronous to clk
//   o_rise - per-bit rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module doorlock_edge
    import doorlock_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] i_sig,
    output logic [WIDTH-1:0] o_rise
);
    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= i_sig;
            r_d2 <= r_d1;
        end
    end

    assign o_rise = r_d1 & ~r_d2;

endmodule
`default_nettype wire

// File: rtl/doorlock_param.sv
`default_nettype none
// ============================================================================
// Module      : doorlock_param
// Description : Parametrised keypad door-lock controller. N_BT buttons enter
//               a CODE_LEN-digit code held in a reprogrammable register;
//               progress, OK/FAIL and lockout are shown on registered LEDs.
//   clk   - system clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - doorlock_param_if.slave (start, prog, bt in; LEDs, busy out)
// Optional feature macro: DOORLOCK_LOCKOUT_EN
//   defined   - MAX_FAIL consecutive failures lock the keypad for LOCK_CYC
//   undefined - unlimited retries, led_lock tied low
// Revision    : 1.0 - initial release
// ============================================================================
module doorlock_param
    import doorlock_pkg::*;
#(
    parameter int N_BT       = 3,
    parameter int CODE_LEN   = 3,
    parameter logic [CODE_LEN*bt_width(N_BT)-1:0] DEF_CODE = {2'd1, 2'd0, 2'd2},
    parameter int TIMEOUT    = 16,
    parameter int RESULT_CYC = 4,
    parameter int MAX_FAIL   = 3,
    parameter int LOCK_CYC   = 64
) (
    input logic clk,
    input logic n_rst,
    doorlock_param_if.slave bus
);
    localparam int c_BT_W  = bt_width(N_BT);
    localparam int c_IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);
    localparam int c_RES_W = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
    localparam int c_CODE_W = CODE_LEN * c_BT_W;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CODE_LEN - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT);
    localparam logic [c_RES_W-1:0] c_RES_LAST = c_RES_W'(RESULT_CYC - 1);

    // Registered state
    state_t                r_state;
    logic                  r_busy;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_match;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_RES_W-1:0]    r_res_cnt;
    logic [c_CODE_W-1:0]   r_code;
    logic [c_CODE_W-1:0]   r_new_code;
    logic [CODE_LEN-1:0]   r_led_digit;
    logic                  r_led_ok;
    logic                  r_led_fail;

    // Combinational decode
    logic [N_BT-1:0]       w_bt_on;
    logic                  w_start_on;
    logic                  w_press;
    logic                  w_single;
    logic [c_BT_W-1:0]     w_digit;
    logic [c_BT_W-1:0]     w_code_digit;
    logic [c_CODE_W-1:0]   w_new_code;
    logic                  w_in_session;
    logic                  w_timeout;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_match_nxt;
    logic                  w_to_ok;
    logic                  w_to_fail;
    logic                  w_to_prog;
    logic                  w_res_done;
    state_t                w_state_nxt;

    doorlock_edge #(.WIDTH(N_BT)) u_bt_edge (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_sig  (bus.bt),
        .o_rise (w_bt_on)
    );

    doorlock_edge #(.WIDTH(1)) u_start_edge (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_sig  (bus.start),
        .o_rise (w_start_on)
    );

    always_comb begin
        w_press      = |w_bt_on;
        w_single     = $onehot(w_bt_on);
        w_digit      = c_BT_W'(oh_to_idx(32'(w_bt_on)));
        w_code_digit = r_code[r_idx*c_BT_W +: c_BT_W];

        // Code as it will look once the current press is stored
        w_new_code = r_new_code;
        w_new_code[r_idx*c_BT_W +: c_BT_W] = w_digit;

        w_in_session = (r_state == c_ST_ENTER) || (r_state == c_ST_AUTH) ||
                       (r_state == c_ST_PROG);
        // Timeout is evaluated before the press so it wins a same-cycle tie
        w_timeout    = w_in_session && (r_timer == c_TMR_MAX);
        w_accept     = w_in_session && !w_timeout && w_press;
        w_done       = w_accept && (r_idx == c_LAST_IDX);
        // A multi-button press can never match, whatever the code holds
        w_match_nxt  = r_match && w_single && (w_digit == w_code_digit);

        w_to_ok   = w_done && (((r_state == c_ST_ENTER) && w_match_nxt) ||
                               (r_state == c_ST_PROG));
        w_to_prog = w_done && (r_state == c_ST_AUTH) && w_match_nxt;
        w_to_fail = w_timeout ||
                    (w_done && (r_state != c_ST_PROG) && !w_match_nxt);

        w_res_done = ((r_state == c_ST_OK) || (r_state == c_ST_FAIL)) &&
                     (r_res_cnt == c_RES_LAST);
    end

`ifdef DOORLOCK_LOCKOUT_EN
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int c_LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX  = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CYC - 1);

    logic [c_FAIL_W-1:0] r_fail_cnt;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic                r_led_lock;
    logic                w_lock_hit;
    logic                w_lock_done;

    // fail_cnt already includes the failure being displayed
    assign w_lock_hit  = (r_fail_cnt >= c_FAIL_MAX);
    assign w_lock_done = (r_state == c_ST_LOCK) && (r_lock_cnt == c_LOCK_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fail_cnt <= '0;
            r_lock_cnt <= '0;
            r_led_lock <= 1'b0;
        end else begin
            if (w_to_ok || w_lock_done) begin
                r_fail_cnt <= '0;
            end else if (w_to_fail && (r_fail_cnt != c_FAIL_MAX)) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end

            if ((r_state != c_ST_LOCK) && (w_state_nxt == c_ST_LOCK)) begin
                r_led_lock <= 1'b1;
                r_lock_cnt <= '0;
            end else if (r_state == c_ST_LOCK) begin
                if (w_lock_done) begin
                    r_led_lock <= 1'b0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.led_lock = r_led_lock;
`else
    // Lockout parameters and state are meaningless in this build
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_FAIL != 0) ^ (LOCK_CYC != 0) ^
                          (c_ST_LOCK != c_ST_IDLE);
    assign bus.led_lock = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_on) w_state_nxt = bus.prog ? c_ST_AUTH : c_ST_ENTER;
            end
            c_ST_ENTER, c_ST_AUTH, c_ST_PROG: begin
                if (w_to_fail)      w_state_nxt = c_ST_FAIL;
                else if (w_to_ok)   w_state_nxt = c_ST_OK;
                else if (w_to_prog) w_state_nxt = c_ST_PROG;
            end
            c_ST_OK: begin
                if (w_res_done) w_state_nxt = c_ST_IDLE;
            end
            c_ST_FAIL: begin
`ifdef DOORLOCK_LOCKOUT_EN
                if (w_res_done) w_state_nxt = w_lock_hit ? c_ST_LOCK : c_ST_IDLE;
`else
                if (w_res_done) w_state_nxt = c_ST_IDLE;
`endif
            end
`ifdef DOORLOCK_LOCKOUT_EN
            c_ST_LOCK: begin
                if (w_lock_done) w_state_nxt = c_ST_IDLE;
            end
`endif
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_match     <= 1'b0;
            r_timer     <= '0;
            r_res_cnt   <= '0;
            r_code      <= DEF_CODE;
            r_new_code  <= '0;
            r_led_digit <= '0;
            r_led_ok    <= 1'b0;
            r_led_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);

            if ((r_state == c_ST_IDLE) && w_start_on) begin
                r_idx   <= '0;
                r_match <= 1'b1;
                r_timer <= '0;
            end else if (w_to_prog) begin
                // Authenticated: restart digit entry for the new code
                r_idx       <= '0;
                r_match     <= 1'b1;
                r_timer     <= '0;
                r_led_digit <= '0;
            end else if (w_accept) begin
                r_idx              <= r_idx + 1'b1;
                r_match            <= w_match_nxt;
                r_timer            <= '0;
                r_led_digit[r_idx] <= 1'b1;
                if (r_state == c_ST_PROG) r_new_code <= w_new_code;
            end else if (w_in_session) begin
                r_timer <= r_timer + 1'b1;
            end

            // Only a completed PROG session commits; timeouts leave the code
            if (w_to_ok && (r_state == c_ST_PROG)) r_code <= w_new_code;

            if ((r_state != c_ST_IDLE) && (w_state_nxt == c_ST_IDLE)) begin
                r_led_digit <= '0;
            end

            if (w_to_ok) begin
                r_led_ok  <= 1'b1;
                r_res_cnt <= '0;
            end else if (w_to_fail) begin
                r_led_fail <= 1'b1;
                r_res_cnt  <= '0;
            end else if ((r_state == c_ST_OK) || (r_state == c_ST_FAIL)) begin
                if (w_res_done) begin
                    r_led_ok   <= 1'b0;
                    r_led_fail <= 1'b0;
                end else begin
                    r_res_cnt <= r_res_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.led_digit = r_led_digit;
    assign bus.led_ok    = r_led_ok;
    assign bus.led_fail  = r_led_fail;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_doorlock_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_doorlock_param
// Description : Self-checking testbench for doorlock_param (default code
//               2,0,1; RESULT_CYC 4; TIMEOUT 16; lockout sequence when
//               DOORLOCK_LOCKOUT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_doorlock_param;

    localparam int RESULT_CYC = 4;
    localparam logic [2:0] B0 = 3'b001;
    localparam logic [2:0] B1 = 3'b010;
    localparam logic [2:0] B2 = 3'b100;
    localparam logic [2:0] NB = 3'b000;

    typedef struct {
        logic            prog;
        int              n;
        logic [5:0][2:0] pats;
        logic            exp_ok;
    } vec_t;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;
    logic res_q[$];

    int   ok_len;
    int   fail_len;
    logic prev_ok;
    logic prev_fail;
    logic exp_res;

    vec_t vecs[10];

    doorlock_param_if #(.N_BT(3), .CODE_LEN(3)) bus ();

    doorlock_param #(
        .N_BT       (3),
        .CODE_LEN   (3),
        .DEF_CODE   ({2'd1, 2'd0, 2'd2}),
        .TIMEOUT    (16),
        .RESULT_CYC (RESULT_CYC),
        .MAX_FAIL   (3),
        .LOCK_CYC   (64)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic p, input int n,
                                input logic [2:0] a0, a1, a2, a3, a4, a5,
                                input logic ok);
        vec_t v;
        v.prog   = p;
        v.n      = n;
        v.pats   = {a5, a4, a3, a2, a1, a0};
        v.exp_ok = ok;
        return v;
    endfunction

    // Result monitor: pops the expected outcome on each result pulse and
    // measures the pulse length.
    always @(negedge clk) begin
        if (!n_rst) begin
            ok_len    = 0;
            fail_len  = 0;
            prev_ok   = 1'b0;
            prev_fail = 1'b0;
        end else begin
            if ((bus.led_ok && !prev_ok) || (bus.led_fail && !prev_fail)) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: ok=%0b fail=%0b none expected",
                             bus.led_ok, bus.led_fail);
                end else begin
                    exp_res = res_q.pop_front();
                    chk("result_ok", 32'(bus.led_ok), 32'(exp_res));
                    chk("result_fail", 32'(bus.led_fail), 32'(!exp_res));
                end
            end
            if (bus.led_ok) ok_len++;
            else if (ok_len != 0) begin
                chk("ok_pulse_len", 32'(ok_len), 32'(RESULT_CYC));
                ok_len = 0;
            end
            if (bus.led_fail) fail_len++;
            else if (fail_len != 0) begin
                chk("fail_pulse_len", 32'(fail_len), 32'(RESULT_CYC));
                fail_len = 0;
            end
            prev_ok   = bus.led_ok;
            prev_fail = bus.led_fail;
        end
    end

    task automatic open_session(input logic p);
        @(posedge clk); #1 bus.start = 1'b1; bus.prog = p;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.start = 1'b0; bus.prog = 1'b0;
    endtask

    // One-cycle button pulse; returns at the negedge after it is consumed
    task automatic press(input logic [2:0] pat);
        @(posedge clk); #1 bus.bt = pat;
        @(posedge clk); #1 bus.bt = NB;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_led_digit_clr"}, 32'(bus.led_digit), 32'd0);
        chk({tag, "_result_seen"}, 32'(res_q.size()), 32'd0);
    endtask

    task automatic drive_vec(input vec_t v, input int id);
        logic [2:0] exp_led;
        res_q.push_back(v.exp_ok);
        open_session(v.prog);
        for (int j = 0; j < v.n; j++) begin
            press(v.pats[j]);
            if (v.prog && (v.n == 6) && (j == 2)) exp_led = 3'b000;
            else if (j >= 3)                      exp_led = 3'((1 << (j - 2)) - 1);
            else                                  exp_led = 3'((1 << (j + 1)) - 1);
            chk($sformatf("v%0d_led_digit_%0d", id, j), 32'(bus.led_digit), 32'(exp_led));
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        drive_vec(v, id);
        wait_idle($sformatf("v%0d", id));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        int n;
        checks    = 0;
        failures  = 0;
        n_rst     = 1'b0;
        bus.start = 1'b0;
        bus.prog  = 1'b0;
        bus.bt    = NB;

        vecs[0] = mk(1'b0, 3, B2, B0, B1, NB, NB, NB, 1'b1);
        vecs[1] = mk(1'b0, 3, B2, B1, B1, NB, NB, NB, 1'b0);
        vecs[2] = mk(1'b1, 6, B2, B0, B1, B1, B1, B0, 1'b1);
        vecs[3] = mk(1'b0, 3, B1, B1, B0, NB, NB, NB, 1'b1);
        vecs[4] = mk(1'b0, 3, B2, B0, B1, NB, NB, NB, 1'b0);
        vecs[5] = mk(1'b0, 3, B1, 3'b011, B0, NB, NB, NB, 1'b0);
        vecs[6] = mk(1'b0, 3, B1, B1, B0, NB, NB, NB, 1'b1);
        vecs[7] = mk(1'b1, 3, B2, B0, B1, NB, NB, NB, 1'b0);
        vecs[8] = mk(1'b1, 6, B1, B1, B0, B2, B0, B1, 1'b1);
        vecs[9] = mk(1'b0, 3, B2, B0, B1, NB, NB, NB, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_led_digit", 32'(bus.led_digit), 32'd0);
        chk("rst_led_ok", 32'(bus.led_ok), 32'd0);
        chk("rst_led_fail", 32'(bus.led_fail), 32'd0);
        chk("rst_led_lock", 32'(bus.led_lock), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1 n_rst = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Inter-press timeout after one digit
        res_q.push_back(1'b0);
        open_session(1'b0);
        press(B2);
        chk("to_led_digit", 32'(bus.led_digit), 32'd1);
        repeat (10) @(negedge clk);
        chk("to_still_busy", 32'(bus.busy), 32'd1);
        chk("to_no_fail_yet", 32'(bus.led_fail), 32'd0);
        wait_idle("timeout");

        // Held button is one press; start edge mid-session is ignored
        res_q.push_back(1'b1);
        open_session(1'b0);
        @(posedge clk); #1 bus.bt = B2;
        repeat (6) @(posedge clk);
        #1 bus.bt = NB;
        @(negedge clk);
        chk("held_single_press", 32'(bus.led_digit), 32'd1);
        @(posedge clk); #1 bus.start = 1'b1; bus.prog = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b0; bus.prog = 1'b0;
        press(B0);
        chk("held_led_digit_1", 32'(bus.led_digit), 32'd3);
        press(B1);
        chk("held_led_digit_2", 32'(bus.led_digit), 32'd7);
        wait_idle("held");

        // Start edge and press in the same cycle: press discarded
        res_q.push_back(1'b1);
        @(posedge clk); #1 bus.start = 1'b1; bus.bt = B2;
        @(posedge clk); #1 bus.bt = NB;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("same_cyc_busy", 32'(bus.busy), 32'd1);
        chk("same_cyc_dropped", 32'(bus.led_digit), 32'd0);
        press(B2);
        press(B0);
        press(B1);
        chk("same_cyc_led_digit", 32'(bus.led_digit), 32'd7);
        wait_idle("same_cyc");

        // Reset mid-session restores the default code
        run_vec(mk(1'b1, 6, B2, B0, B1, B1, B1, B0, 1'b1), 20);
        open_session(1'b0);
        press(B1);
        chk("mid_rst_pre_digit", 32'(bus.led_digit), 32'd1);
        n_rst  = 1'b0;
        bus.bt = NB;
        #2;
        chk("mid_rst_led_digit", 32'(bus.led_digit), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1 n_rst = 1'b1;
        run_vec(mk(1'b0, 3, B1, B1, B0, NB, NB, NB, 1'b0), 21);
        run_vec(mk(1'b0, 3, B2, B0, B1, NB, NB, NB, 1'b1), 22);

        // Three consecutive wrong codes
        run_vec(mk(1'b0, 3, B2, B1, B1, NB, NB, NB, 1'b0), 30);
        run_vec(mk(1'b0, 3, B2, B1, B1, NB, NB, NB, 1'b0), 31);
`ifdef DOORLOCK_LOCKOUT_EN
        drive_vec(mk(1'b0, 3, B2, B1, B1, NB, NB, NB, 1'b0), 32);
        n = 0;
        while (!bus.led_lock && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("lock_entered", 32'(bus.led_lock), 32'd1);
        len = 0;
        while (bus.led_lock && len < 200) begin
            if (len == 5)  bus.start = 1'b1;
            if (len == 8)  bus.start = 1'b0;
            if (len == 12) bus.bt = B2;
            if (len == 14) bus.bt = NB;
            if (len == 20) chk("lock_busy", 32'(bus.busy), 32'd1);
            @(negedge clk);
            len++;
        end
        chk("lock_len", 32'(len), 32'd64);
        chk("lock_busy_clear", 32'(bus.busy), 32'd0);
        chk("lock_led_digit", 32'(bus.led_digit), 32'd0);
        chk("lock_result_seen", 32'(res_q.size()), 32'd0);
`else
        run_vec(mk(1'b0, 3, B2, B1, B1, NB, NB, NB, 1'b0), 32);
        chk("no_lock", 32'(bus.led_lock), 32'd0);
`endif
        run_vec(mk(1'b0, 3, B2, B0, B1, NB, NB, NB, 1'b1), 33);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/doorlock_param.md
# doorlock_param

Parametrised keypad door-lock controller: N_BT push-buttons, a CODE_LEN-digit code held in a reprogrammable register, per-digit progress LEDs, OK/FAIL result display, inter-press timeout and optional brute-force lockout. It replaces the fixed 3-button, hard-coded-sequence door lock and sits between the raw button/start inputs and the LED drivers.

## Interface
- N_BT, 3: number of buttons; digit value = button index, width BT_W = $clog2(N_BT) (min 1)
- CODE_LEN, 3: digits per code
- DEF_CODE, {2'd1,2'd0,2'd2}: reset code, packed CODE_LEN×BT_W; digit 0 in LSBs (default sequence 2,0,1)
- TIMEOUT, 16: max cycles between accepted presses inside a session
- RESULT_CYC, 4: cycles led_ok/led_fail stay lit
- MAX_FAIL, 3: consecutive failures before lockout
- LOCK_CYC, 64: lockout duration in cycles
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  level; rising edge opens a session
- prog  in  1  sampled on the start edge; 1 = reprogram session
- bt  in  N_BT  raw button levels, synchronous to clk
- led_digit  out  CODE_LEN  thermometer progress, bit i = digit i entered
- led_ok  out  1  success pulse, RESULT_CYC long
- led_fail  out  1  failure pulse, RESULT_CYC long
- led_lock  out  1  lockout active
- busy  out  1  FSM not in IDLE

## Operation
- Edge detect: bt_d1 <= bt, bt_d2 <= bt_d1; bt_on = bt_d1 & ~bt_d2. Same for start.
- Press: any cycle with bt_on != 0. Exactly one bit set -> digit = its index; more than one bit -> digit counted as wrong.
- States: IDLE, ENTER, AUTH, PROG, OK, FAIL, LOCK.
- IDLE: start edge -> ENTER (prog=0) or AUTH (prog=1); digit index, match flag (=1), timer cleared.
- ENTER/AUTH: each press sets led_digit[idx], match &= (digit == code[idx]), idx++, timer cleared. Comparison never aborts early. After digit CODE_LEN-1: ENTER -> OK if match else FAIL; AUTH -> PROG (led_digit cleared, idx=0) if match else FAIL.
- PROG: each press writes new_code[idx]; after last digit code register <= new_code, -> OK.
- Timeout: timer reaches TIMEOUT in ENTER/AUTH/PROG -> FAIL; code register unchanged.
- start edges outside IDLE ignored; prog ignored outside the start edge.
- OK: led_ok=1 for RESULT_CYC, fail_cnt cleared, -> IDLE. FAIL: led_fail=1 for RESULT_CYC, fail_cnt++ (saturating), -> IDLE (or LOCK, see Configuration).
- led_digit cleared on entry to IDLE.
- Reset mid-operation: all state, counters, LEDs cleared; code register returns to DEF_CODE.

## Timing
- All outputs registered; reset value 0 for every output.
- bt rising before edge k: bt_d1 set at k, bt_on high cycle k..k+1, led_digit bit set at edge k+1 (2-cycle press latency).
- Last digit consumed at edge k+1 -> led_ok/led_fail high from k+1 for exactly RESULT_CYC cycles.
- Button held high produces one press only; re-press needs one low cycle.
- start edge and press in the same cycle: session opens, press discarded.
- Press on the cycle the timer expires: timeout wins.

## Configuration
- DOORLOCK_LOCKOUT_EN defined: fail_cnt (width $clog2(MAX_FAIL+1)) present; FAIL with fail_cnt reaching MAX_FAIL -> LOCK after result display; LOCK holds led_lock=1, busy=1, ignores start/bt for LOCK_CYC cycles, clears fail_cnt, -> IDLE.
- Undefined: no fail_cnt, no LOCK state, led_lock tied 0; unlimited retries.

## Structure
- doorlock_pkg: state encoding localparams, helper for BT_W, one-hot-to-index function.
- Sub-module doorlock_edge: parametrised N-wide two-flop rising-edge detector, used for bt and start.

## Test plan
- Reset release, start edge, press 2,0,1 -> led_digit 001,011,111; led_ok high 4 cycles; busy falls after.
- Press 2,1,1 -> all three digits lit, led_fail 4 cycles, no early abort after digit 1.
- Press 2 then idle 16 cycles -> led_fail 4 cycles, led_digit cleared on return to IDLE.
- prog=1 session: 2,0,1 then 1,1,0 -> led_ok; next session 1,1,0 -> led_ok, 2,0,1 -> led_fail.
- bt=3'b011 pressed as a digit -> wrong digit, final led_fail; held button gives single press.
- With DOORLOCK_LOCKOUT_EN: three wrong codes -> led_lock high 64 cycles, start ignored; then 2,0,1 -> led_ok.
